// File: rtl/mem_port_requester.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_requester
// Purpose  : Buffers cache read/writeback requests in an in-order FIFO and
//            runs one message-protocol transaction at a time on a memory port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_requester #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MSG_BITS      = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter logic [MSG_BITS-1:0] NO_REQ     = MSG_BITS'(0),
  parameter logic [MSG_BITS-1:0] WB_REQ     = MSG_BITS'(1),
  parameter logic [MSG_BITS-1:0] R_REQ      = MSG_BITS'(2),
  parameter logic [MSG_BITS-1:0] MEM_NO_MSG = MSG_BITS'(4),
  parameter logic [MSG_BITS-1:0] MEM_READY  = MSG_BITS'(5),
  parameter logic [MSG_BITS-1:0] MEM_SENT   = MSG_BITS'(6)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_data,
  output logic                     resp_valid,
  output logic                     resp_write,
  output logic [ADDRESS_WIDTH-1:0] resp_address,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic [MSG_BITS-1:0]      mem_msg_out,
  output logic [ADDRESS_WIDTH-1:0] mem_address_out,
  output logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic [MSG_BITS-1:0]      mem_msg_in,
  input  logic [ADDRESS_WIDTH-1:0] mem_address_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_in
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Request FIFO storage and bookkeeping
  logic [ADDRESS_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    r_fifo_write;
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [c_cnt_w-1:0]       r_count;

  logic w_push;
  logic w_pop;
  logic w_nonempty;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [MSG_BITS-1:0]      r_mem_msg,  w_mem_msg_next;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_WIDTH-1:0]    r_mem_data, w_mem_data_next;
  logic                     r_resp_valid, w_resp_valid_next;
  logic                     r_resp_write, w_resp_write_next;
  logic [ADDRESS_WIDTH-1:0] r_resp_addr,  w_resp_addr_next;
  logic [DATA_WIDTH-1:0]    r_resp_data,  w_resp_data_next;

  logic w_addr_hit;
  logic w_read_match;
  logic w_write_match;

  assign req_ready  = (r_count != c_full_count);
  assign w_nonempty = (r_count != '0);
  assign w_push     = req_valid & req_ready;

  assign w_addr_hit    = (mem_address_in == r_mem_addr);
  assign w_read_match  = (r_mem_msg == R_REQ)  && (mem_msg_in == MEM_SENT)  && w_addr_hit;
  assign w_write_match = (r_mem_msg == WB_REQ) && (mem_msg_in == MEM_READY) && w_addr_hit;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr]  <= req_address;
      r_fifo_data[r_wr_ptr]  <= req_write ? req_data : '0;
      r_fifo_write[r_wr_ptr] <= req_write;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state and next-output logic; registered below so every port is a flop
  always_comb begin
    w_state_next      = r_state;
    w_pop             = 1'b0;
    w_mem_msg_next    = r_mem_msg;
    w_mem_addr_next   = r_mem_addr;
    w_mem_data_next   = r_mem_data;
    w_resp_valid_next = 1'b0;
    w_resp_write_next = r_resp_write;
    w_resp_addr_next  = r_resp_addr;
    w_resp_data_next  = r_resp_data;

    case (r_state)
      ST_IDLE: begin
        if (w_nonempty) begin
          w_pop           = 1'b1;
          w_mem_msg_next  = r_fifo_write[r_rd_ptr] ? WB_REQ : R_REQ;
          w_mem_addr_next = r_fifo_addr[r_rd_ptr];
          w_mem_data_next = r_fifo_data[r_rd_ptr];
          w_state_next    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_read_match || w_write_match) begin
          w_mem_msg_next    = NO_REQ;
          w_mem_addr_next   = '0;
          w_mem_data_next   = '0;
          w_resp_valid_next = 1'b1;
          w_resp_write_next = w_write_match;
          w_resp_addr_next  = r_mem_addr;
          w_resp_data_next  = w_read_match ? mem_data_in : '0;
          w_state_next      = ST_DONE;
        end
      end
      ST_DONE: begin
        // One NO_REQ cycle lets memory settle back to idle first
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_mem_msg_next  = NO_REQ;
        w_mem_addr_next = '0;
        w_mem_data_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mem_msg    <= NO_REQ;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_write <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mem_msg    <= w_mem_msg_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_data   <= w_mem_data_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_write <= w_resp_write_next;
      r_resp_addr  <= w_resp_addr_next;
      r_resp_data  <= w_resp_data_next;
    end
  end

  assign mem_msg_out     = r_mem_msg;
  assign mem_address_out = r_mem_addr;
  assign mem_data_out    = r_mem_data;
  assign resp_valid      = r_resp_valid;
  assign resp_write      = r_resp_write;
  assign resp_address    = r_resp_addr;
  assign resp_data       = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_requester
// Purpose  : Randomized bench with a reactive memory model and a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_requester;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 3;
  localparam int DEPTH = 4;
  localparam logic [MB-1:0] NO_REQ     = 3'd0;
  localparam logic [MB-1:0] WB_REQ     = 3'd1;
  localparam logic [MB-1:0] R_REQ      = 3'd2;
  localparam logic [MB-1:0] MEM_NO_MSG = 3'd4;
  localparam logic [MB-1:0] MEM_READY  = 3'd5;
  localparam logic [MB-1:0] MEM_SENT   = 3'd6;

  logic          clock;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_write;
  logic [AW-1:0] resp_address;
  logic [DW-1:0] resp_data;
  logic [MB-1:0] mem_msg_out, mem_msg_in;
  logic [AW-1:0] mem_address_out, mem_address_in;
  logic [DW-1:0] mem_data_out, mem_data_in;

  mem_port_requester #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB), .FIFO_DEPTH(DEPTH),
    .NO_REQ(NO_REQ), .WB_REQ(WB_REQ), .R_REQ(R_REQ),
    .MEM_NO_MSG(MEM_NO_MSG), .MEM_READY(MEM_READY), .MEM_SENT(MEM_SENT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_write(resp_write),
    .resp_address(resp_address), .resp_data(resp_data),
    .mem_msg_out(mem_msg_out), .mem_address_out(mem_address_out),
    .mem_data_out(mem_data_out), .mem_msg_in(mem_msg_in),
    .mem_address_in(mem_address_in), .mem_data_in(mem_data_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } resp_t;

  // Reference model: architectural memory view in request order
  resp_t         exp_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  int            n_resp = 0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic ref_push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    resp_t e;
    e.w = w;
    e.a = a;
    if (w) begin
      ref_mem[a] = d;
      e.d = '0;
    end else begin
      e.d = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    end
    exp_q.push_back(e);
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_address = a; req_data = d;
    while (!req_ready && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    if (!req_ready) begin
      check("push_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clock);
      ref_push(w, a, d);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (4) @(posedge clock);
    #1;
  endtask

  // Reactive memory: answers each transaction once after a random delay
  int            mm_max_dly = 0;
  int            mm_dly = 0;
  int            mm_spur = 0;
  bit            mm_stall = 1'b0;
  bit            mm_active = 1'b0;
  logic [AW-1:0] mm_addr;
  logic [DW-1:0] mm_data;

  initial begin
    mem_msg_in = MEM_NO_MSG; mem_address_in = '0; mem_data_in = '0;
    forever begin
      @(posedge clock); #1;
      mem_msg_in = MEM_NO_MSG; mem_address_in = '0; mem_data_in = '0;
      if (reset || mem_msg_out == NO_REQ) begin
        mm_active = 1'b0;
      end else begin
        if (!mm_active) begin
          mm_active = 1'b1;
          mm_dly  = $urandom_range(0, mm_max_dly);
          mm_addr = mem_address_out;
          mm_data = mem_data_out;
          if (mem_msg_out == R_REQ) check("rd_data_zero", mem_data_out, 0);
        end
        if (mm_spur > 0) begin
          mm_spur--;
          mem_data_in = $urandom;
          if (mm_spur[0]) begin
            mem_msg_in     = (mem_msg_out == WB_REQ) ? MEM_READY : MEM_SENT;
            mem_address_in = mem_address_out + 32'd4;
          end else begin
            mem_msg_in     = (mem_msg_out == WB_REQ) ? MEM_SENT : MEM_READY;
            mem_address_in = mem_address_out;
          end
        end else if (!mm_stall) begin
          if (mm_dly > 0) begin
            mm_dly--;
          end else begin
            check("mem_addr_stable", mem_address_out, mm_addr);
            check("mem_data_stable", mem_data_out, mm_data);
            mem_address_in = mem_address_out;
            if (mem_msg_out == WB_REQ) begin
              mem_arr[mem_address_out] = mem_data_out;
              mem_msg_in = MEM_READY;
            end else begin
              mem_msg_in  = MEM_SENT;
              mem_data_in = mem_arr.exists(mem_address_out) ? mem_arr[mem_address_out]
                                                            : init_word(mem_address_out);
            end
          end
        end
      end
    end
  end

  // Response scoreboard and NO_REQ spacing monitor
  int mon_run = 0;
  bit mon_seen = 1'b0;
  resp_t mon_e;

  initial begin
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        mon_run = 0;
        mon_seen = 1'b0;
      end else begin
        if (resp_valid) begin
          n_resp++;
          check("resp_msg_noreq", mem_msg_out, NO_REQ);
          if (exp_q.size() == 0) begin
            check("resp_unexpected", 64'd1, 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("resp_write", resp_write, mon_e.w);
            check("resp_address", resp_address, mon_e.a);
            check("resp_data", resp_data, mon_e.d);
          end
        end
        if (mem_msg_out == NO_REQ) begin
          mon_run++;
        end else begin
          if (mon_run > 0 && mon_seen) check("noreq_gap", 64'(mon_run >= 2), 64'd1);
          mon_run = 0;
          mon_seen = 1'b1;
        end
      end
    end
  end

  int base;
  int n_push;
  logic [AW-1:0] a;
  logic          w;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_msg", mem_msg_out, NO_REQ);
    check("rst_maddr", mem_address_out, 0);
    check("rst_mdata", mem_data_out, 0);
    check("rst_rvalid", resp_valid, 0);
    check("rst_rwrite", resp_write, 0);
    check("rst_raddr", resp_address, 0);
    check("rst_rdata", resp_data, 0);
    check("rst_ready", req_ready, 1);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      check("idle_msg", mem_msg_out, NO_REQ);
      check("idle_ready", req_ready, 1);
      check("idle_rvalid", resp_valid, 0);
    end

    // Single read
    mem_arr[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    mm_max_dly = 3;
    base = n_resp;
    push(1'b0, 32'h40, $urandom);
    drain();
    check("single_pulses", n_resp - base, 1);

    // Writeback then read same address
    base = n_resp;
    push(1'b1, 32'h80, 32'h1234_5678);
    push(1'b0, 32'h80, $urandom);
    drain();
    check("wb_rd_pulses", n_resp - base, 2);

    // Fill the FIFO while memory stalls
    mm_stall = 1'b1;
    base = n_resp;
    for (int i = 0; i < 5; i++) begin
      push(i[0], 32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i));
      if (i == 3) check("ready_before_full", req_ready, 1);
    end
    check("full_ready", req_ready, 0);
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h214; req_data = '0;
    repeat (5) begin
      @(posedge clock); #1;
      check("full_hold", req_ready, 0);
    end
    check("full_head_msg", mem_msg_out, R_REQ);
    req_valid = 1'b0;
    mm_stall = 1'b0;
    push(1'b0, 32'h214, 32'h0);
    push(1'b0, 32'h204, 32'h0);
    drain();
    check("full_pulses", n_resp - base, 7);

    // Spurious responses ignored
    mm_stall = 1'b1;
    base = n_resp;
    push(1'b0, 32'h40, $urandom);
    @(posedge clock); #1;
    mm_spur = 2;
    repeat (5) @(posedge clock);
    #1;
    check("spur_msg", mem_msg_out, R_REQ);
    check("spur_addr", mem_address_out, 32'h40);
    check("spur_pulses", n_resp - base, 0);
    mm_stall = 1'b0;
    drain();
    check("spur_done_pulses", n_resp - base, 1);

    // Reset mid-transaction with queued entries
    mm_stall = 1'b1;
    base = n_resp;
    push(1'b0, 32'h300, 32'h0);
    push(1'b0, 32'h304, 32'h0);
    push(1'b0, 32'h308, 32'h0);
    @(posedge clock); #1;
    check("pre_rst_msg", mem_msg_out, R_REQ);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    check("mid_rst_msg", mem_msg_out, NO_REQ);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_rvalid", resp_valid, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    mm_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      check("post_rst_msg", mem_msg_out, NO_REQ);
    end
    check("post_rst_pulses", n_resp - base, 0);

    // Randomized traffic over a small address window to force hazards
    mm_max_dly = 4;
    base = n_resp;
    n_push = 0;
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'h100 + 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 7) == 0) mm_spur = 2;
      push(w, a, $urandom);
      n_push++;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    drain();
    check("rand_pulses", n_resp - base, n_push);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
